// File: rtl/conv_pkg.sv
// Shared conv accumulator definitions: default geometry and write-back FSM encoding.
package conv_pkg;

   localparam int unsigned AW_DEF = 11;
   localparam int unsigned DW_DEF = 22;
   localparam int unsigned DN_DEF = 6;
   localparam int unsigned FD_DEF = 16;
   localparam int unsigned SIZE_W = 8;
   localparam int unsigned WORD_W = DW_DEF * DN_DEF;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/conv_sfifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on data_o whenever not empty.
module conv_sfifo import conv_pkg::*; #(
   parameter int unsigned W  = WORD_W,
   parameter int unsigned FD = FD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [W-1:0]          data_i,
   output logic [W-1:0]          data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [$clog2(FD):0]   level_o
);

   localparam int unsigned PW = $clog2(FD);
   localparam int unsigned LW = PW + 1;

   logic [W-1:0]  mem_q [FD];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(FD));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Mask the head so the port reads zero while nothing is stored.
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/conv_psum_wr.sv
// Partial-sum write-back: streams m_sum into the psum RAM from a commanded base address,
// and buffers the final-result stream toward the output DMA.
module conv_psum_wr import conv_pkg::*; #(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned DN = DN_DEF,
   parameter int unsigned FD = FD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base,
   input  logic [SIZE_W-1:0]     size,
   input  logic [DW*DN-1:0]      m_sum,
   input  logic                  m_valid,
   input  logic [DW*DN-1:0]      s_sum,
   input  logic                  s_valid,
   output logic                  w_en,
   output logic [AW-1:0]         w_addr,
   output logic [DW*DN-1:0]      w_data,
   output logic                  wover,
   output logic                  busy,
   output logic [DW*DN-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(FD):0]   fifo_level,
   input  logic                  err_clr,
   output logic                  err_seq,
   output logic                  err_ovf
);

   localparam int unsigned WW = DW * DN;

   wr_state_e         state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [SIZE_W-1:0] rem_q, rem_d;
   logic              w_en_q, w_en_d;
   logic [AW-1:0]     w_addr_q, w_addr_d;
   logic [WW-1:0]     w_data_q, w_data_d;
   logic              wover_q, wover_d;
   logic              err_seq_q, err_seq_d;
   logic              err_ovf_q, err_ovf_d;
   logic              seq_set;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop, ovf_set;

   // Pass sequencing: address/count bookkeeping and registered RAM write port.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      wover_d  = 1'b0;
      seq_set  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (size != '0) begin
                  addr_d  = base;
                  rem_d   = size;
                  state_d = ST_WRITE;
               end else begin
                  wover_d = 1'b1;
               end
            end
            if (m_valid) seq_set = 1'b1;
         end
         ST_WRITE: begin
            if (m_valid) begin
               w_en_d   = 1'b1;
               w_addr_d = addr_q;
               w_data_d = m_sum;
               addr_d   = addr_q + AW'(1);
               rem_d    = rem_q - SIZE_W'(1);
               if (rem_q == SIZE_W'(1)) begin
                  wover_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            if (start) seq_set = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      err_seq_d = err_clr ? 1'b0 : (err_seq_q | seq_set);
      err_ovf_d = err_clr ? 1'b0 : (err_ovf_q | ovf_set);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         w_en_q    <= 1'b0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
         wover_q   <= 1'b0;
         err_seq_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         w_en_q    <= w_en_d;
         w_addr_q  <= w_addr_d;
         w_data_q  <= w_data_d;
         wover_q   <= wover_d;
         err_seq_q <= err_seq_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   assign w_en    = w_en_q;
   assign w_addr  = w_addr_q;
   assign w_data  = w_data_q;
   assign wover   = wover_q;
   assign busy    = (state_q == ST_WRITE);
   assign err_seq = err_seq_q;
   assign err_ovf = err_ovf_q;

   // A pop in the same cycle frees the slot, so a full FIFO still takes the incoming word.
   assign out_valid = ~fifo_empty;
   assign fifo_pop  = out_valid & out_ready;
   assign fifo_push = s_valid & (~fifo_full | fifo_pop);
   assign ovf_set   = s_valid & fifo_full & ~fifo_pop;

   conv_sfifo #(
      .W  (WW),
      .FD (FD)
   ) u_final_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (s_sum),
      .data_o  (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

endmodule

// File: tb/tb_conv_psum_wr.sv
// Directed self-checking bench for conv_psum_wr: write passes, address wrap, sequencing errors,
// final FIFO fill/drain/overflow and mid-pass reset.
module tb_conv_psum_wr;

   localparam int unsigned AW = 11;
   localparam int unsigned CW = 132;
   localparam int unsigned LW = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [AW-1:0]  base;
   logic [7:0]     size;
   logic [CW-1:0]  m_sum;
   logic           m_valid;
   logic [CW-1:0]  s_sum;
   logic           s_valid;
   logic           w_en;
   logic [AW-1:0]  w_addr;
   logic [CW-1:0]  w_data;
   logic           wover;
   logic           busy;
   logic [CW-1:0]  out_data;
   logic           out_valid;
   logic           out_ready;
   logic [LW-1:0]  fifo_level;
   logic           err_clr;
   logic           err_seq;
   logic           err_ovf;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] aq[$];
   logic [CW-1:0] dq[$];
   int            wov_cnt;
   logic          wov_wen;
   logic [AW-1:0] wov_addr;

   conv_psum_wr dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base       (base),
      .size       (size),
      .m_sum      (m_sum),
      .m_valid    (m_valid),
      .s_sum      (s_sum),
      .s_valid    (s_valid),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .wover      (wover),
      .busy       (busy),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .err_clr    (err_clr),
      .err_seq    (err_seq),
      .err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   // Record every RAM write and pass completion on the falling edge.
   always @(negedge clk) begin
      if (w_en) begin
         aq.push_back(w_addr);
         dq.push_back(w_data);
      end
      if (wover) begin
         wov_cnt  = wov_cnt + 1;
         wov_wen  = w_en;
         wov_addr = w_addr;
      end
   end

   function automatic logic [CW-1:0] mk(input int k);
      return {32'(k), 32'hC0DE_0000 + 32'(k), 68'(k) ^ 68'h5_A5A5_A5A5_0000_0000};
   endfunction

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      aq.delete();
      dq.delete();
      wov_cnt  = 0;
      wov_wen  = 1'b0;
      wov_addr = '0;
   endtask

   task automatic start_cmd(input logic [AW-1:0] b, input logic [7:0] s);
      start = 1'b1;
      base  = b;
      size  = s;
      tick();
      start = 1'b0;
   endtask

   task automatic run_words(input int n, input int k0);
      for (int i = 0; i < n; i++) begin
         m_valid = 1'b1;
         m_sum   = mk(k0 + i);
         tick();
      end
      m_valid = 1'b0;
   endtask

   task automatic fill_fifo(input int n, input int k0);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_sum   = mk(k0 + i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base = '0; size = '0; m_sum = '0; m_valid = 1'b0;
      s_sum = '0; s_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      clear_mon();
      repeat (3) tick();
      check("rst_w_en",   CW'(w_en),       CW'(0));
      check("rst_busy",   CW'(busy),       CW'(0));
      check("rst_wover",  CW'(wover),      CW'(0));
      check("rst_oval",   CW'(out_valid),  CW'(0));
      check("rst_level",  CW'(fifo_level), CW'(0));
      check("rst_errs",   CW'({err_seq, err_ovf}), CW'(0));
      rst_n = 1'b1;
      tick();

      // 1: basic pass of four words
      clear_mon();
      start_cmd(11'h010, 8'd4);
      check("p1_busy", CW'(busy), CW'(1));
      run_words(4, 0);
      check("p1_wover_now", CW'(wover), CW'(1));
      repeat (2) tick();
      check("p1_nwr", CW'(aq.size()), CW'(4));
      for (int i = 0; i < 4 && i < aq.size(); i++) begin
         check("p1_addr", CW'(aq[i]), CW'(11'h010 + 11'(i)));
         check("p1_data", dq[i], mk(i));
      end
      check("p1_wov_cnt",  CW'(wov_cnt),  CW'(1));
      check("p1_wov_wen",  CW'(wov_wen),  CW'(1));
      check("p1_wov_addr", CW'(wov_addr), CW'(11'h013));
      check("p1_busy_end", CW'(busy),     CW'(0));

      // 2: address wrap
      clear_mon();
      start_cmd(11'h7FE, 8'd3);
      run_words(3, 10);
      repeat (2) tick();
      check("p2_nwr", CW'(aq.size()), CW'(3));
      if (aq.size() == 3) begin
         check("p2_a0", CW'(aq[0]), CW'(11'h7FE));
         check("p2_a1", CW'(aq[1]), CW'(11'h7FF));
         check("p2_a2", CW'(aq[2]), CW'(11'h000));
         check("p2_d2", dq[2], mk(12));
      end
      check("p2_wov_cnt", CW'(wov_cnt), CW'(1));

      // 3a: zero-size command
      clear_mon();
      start_cmd(11'h055, 8'd0);
      check("p3_z_wover", CW'(wover), CW'(1));
      check("p3_z_busy",  CW'(busy),  CW'(0));
      tick();
      check("p3_z_wover_off", CW'(wover), CW'(0));
      check("p3_z_nwr", CW'(aq.size()), CW'(0));

      // 3b: back-to-back passes, new start on the wover cycle
      clear_mon();
      start_cmd(11'h020, 8'd2);
      run_words(2, 20);
      check("p3_b_wover", CW'(wover), CW'(1));
      start_cmd(11'h100, 8'd2);
      check("p3_b_busy", CW'(busy), CW'(1));
      run_words(2, 30);
      repeat (2) tick();
      check("p3_b_nwr", CW'(aq.size()), CW'(4));
      if (aq.size() == 4) begin
         check("p3_b_a1", CW'(aq[1]), CW'(11'h021));
         check("p3_b_a2", CW'(aq[2]), CW'(11'h100));
         check("p3_b_d3", dq[3], mk(31));
      end
      check("p3_b_wov_cnt", CW'(wov_cnt), CW'(2));
      check("p3_b_err", CW'(err_seq), CW'(0));

      // 4: sequencing errors
      clear_mon();
      m_valid = 1'b1; m_sum = mk(99);
      tick();
      m_valid = 1'b0;
      check("p4_idle_mv_err", CW'(err_seq), CW'(1));
      repeat (2) tick();
      check("p4_idle_mv_nwr", CW'(aq.size()), CW'(0));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("p4_clr", CW'(err_seq), CW'(0));
      err_clr = 1'b1; m_valid = 1'b1;
      tick();
      err_clr = 1'b0; m_valid = 1'b0;
      check("p4_clr_wins", CW'(err_seq), CW'(0));
      start_cmd(11'h040, 8'd2);
      m_valid = 1'b1; m_sum = mk(40);
      start = 1'b1; base = 11'h300; size = 8'd7;
      tick();
      start = 1'b0;
      check("p4_wr_start_err", CW'(err_seq), CW'(1));
      m_sum = mk(41);
      tick();
      m_valid = 1'b0;
      check("p4_wover", CW'(wover), CW'(1));
      repeat (2) tick();
      check("p4_nwr", CW'(aq.size()), CW'(2));
      if (aq.size() == 2) check("p4_a1", CW'(aq[1]), CW'(11'h041));
      check("p4_wov_cnt", CW'(wov_cnt), CW'(1));
      check("p4_busy", CW'(busy), CW'(0));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // 5: FIFO overflow then in-order drain
      fill_fifo(17, 100);
      check("p5_level", CW'(fifo_level), CW'(16));
      check("p5_ovf",   CW'(err_ovf),    CW'(1));
      check("p5_head",  out_data,        mk(100));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("p5_ovf_clr", CW'(err_ovf), CW'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("p5_drain", out_data, mk(100 + i));
         tick();
      end
      out_ready = 1'b0;
      check("p5_empty", CW'(out_valid), CW'(0));
      check("p5_level0", CW'(fifo_level), CW'(0));

      // 6a: push and pop together while full
      fill_fifo(16, 150);
      check("p6_full", CW'(fifo_level), CW'(16));
      s_valid = 1'b1; s_sum = mk(200); out_ready = 1'b1;
      tick();
      s_valid = 1'b0; out_ready = 1'b0;
      check("p6_level", CW'(fifo_level), CW'(16));
      check("p6_noovf", CW'(err_ovf),    CW'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("p6_drain", out_data, (i < 15) ? mk(151 + i) : mk(200));
         tick();
      end
      out_ready = 1'b0;
      check("p6_empty", CW'(out_valid), CW'(0));

      // 6b: reset in the middle of a pass
      fill_fifo(3, 300);
      m_valid = 1'b1; m_sum = mk(299);
      tick();
      m_valid = 1'b0;
      start_cmd(11'h050, 8'd5);
      run_words(2, 50);
      check("p6_pre_busy", CW'(busy), CW'(1));
      clear_mon();
      #2;
      rst_n = 1'b0;
      #1;
      check("p6_rst_w_en",  CW'(w_en),       CW'(0));
      check("p6_rst_addr",  CW'(w_addr),     CW'(0));
      check("p6_rst_data",  w_data,          CW'(0));
      check("p6_rst_wover", CW'(wover),      CW'(0));
      check("p6_rst_busy",  CW'(busy),       CW'(0));
      check("p6_rst_oval",  CW'(out_valid),  CW'(0));
      check("p6_rst_odata", out_data,        CW'(0));
      check("p6_rst_level", CW'(fifo_level), CW'(0));
      check("p6_rst_errs",  CW'({err_seq, err_ovf}), CW'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("p6_post_wov", CW'(wov_cnt),   CW'(0));
      check("p6_post_nwr", CW'(aq.size()), CW'(0));
      check("p6_post_busy", CW'(busy),     CW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
